// File: rtl/quadra_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : quadra_coef_loader
// Function : framed stream writer for the quadra {a,b,c} coefficient table
// Revision : 1.0
// ============================================================================
module quadra_coef_loader #(
  parameter int         SEG_BITS = 7,
  parameter int         COEF_W   = 32,
  parameter logic [7:0] MAGIC    = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [31:0]         s_data,
  input  logic                s_last,
  input  logic                rd_en,
  input  logic [SEG_BITS-1:0] rd_idx,
  output logic                rd_vld,
  output logic [COEF_W-1:0]   rd_a,
  output logic [COEF_W-1:0]   rd_b,
  output logic [COEF_W-1:0]   rd_c,
  output logic                busy,
  output logic                table_valid,
  output logic                err,
  output logic                load_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WA    = 3'd1,
    ST_WB    = 3'd2,
    ST_WC    = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [SEG_BITS-1:0]   r_idx;
  logic [7:0]            r_rem;
  logic [COEF_W-1:0]     r_sha;
  logic [COEF_W-1:0]     r_shb;
  logic                  r_err;
  logic                  r_tv;
  logic                  r_ld;
  logic                  r_rd_vld;
  logic [COEF_W-1:0]     r_rd_a;
  logic [COEF_W-1:0]     r_rd_b;
  logic [COEF_W-1:0]     r_rd_c;
  logic [3*COEF_W-1:0]   r_tab [2**SEG_BITS];

  logic                  w_acc;
  logic                  w_commit;
  logic [COEF_W-1:0]     w_word;
  logic [3*COEF_W-1:0]   w_rd;
  logic                  w_unused;

  assign w_acc    = s_valid & r_ready;
  assign w_commit = w_acc && (r_state == ST_WC);
  assign w_word   = COEF_W'(s_data);
  assign w_rd     = r_tab[rd_idx];
  assign w_unused = &{1'b0, s_data[15:SEG_BITS]};

  // Table is deliberately unreset; a concurrent read sees the pre-commit entry.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_tab[r_idx] <= {r_sha, r_shb, w_word};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b0;
      r_idx    <= '0;
      r_rem    <= '0;
      r_sha    <= '0;
      r_shb    <= '0;
      r_err    <= 1'b0;
      r_tv     <= 1'b0;
      r_ld     <= 1'b0;
      r_rd_vld <= 1'b0;
      r_rd_a   <= '0;
      r_rd_b   <= '0;
      r_rd_c   <= '0;
    end else begin
      r_ready  <= 1'b1;
      r_ld     <= 1'b0;
      r_rd_vld <= rd_en;
      if (rd_en) begin
        r_rd_a <= w_rd[3*COEF_W-1:2*COEF_W];
        r_rd_b <= w_rd[2*COEF_W-1:COEF_W];
        r_rd_c <= w_rd[COEF_W-1:0];
      end
      if (w_acc) begin
        case (r_state)
          ST_IDLE: begin
            if (s_data[31:24] == MAGIC) begin
              // A header that is also the last word is an empty, broken frame.
              r_err <= s_last;
              r_tv  <= 1'b0;
              r_idx <= s_data[SEG_BITS-1:0];
              r_rem <= s_data[23:16];
              if (!s_last) r_state <= ST_WA;
            end else begin
              r_err <= 1'b1;
              if (!s_last) r_state <= ST_DRAIN;
            end
          end
          ST_WA: begin
            if (s_last) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_sha   <= w_word;
              r_state <= ST_WB;
            end
          end
          ST_WB: begin
            if (s_last) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_shb   <= w_word;
              r_state <= ST_WC;
            end
          end
          ST_WC: begin
            if (r_rem != 8'd0) begin
              if (s_last) begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_rem   <= r_rem - 8'd1;
                r_idx   <= r_idx + 1'b1;
                r_state <= ST_WA;
              end
            end else if (s_last) begin
              r_tv    <= 1'b1;
              r_ld    <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (s_last) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_ready     = r_ready;
  assign busy        = (r_state != ST_IDLE);
  assign table_valid = r_tv;
  assign err         = r_err;
  assign load_done   = r_ld;
  assign rd_vld      = r_rd_vld;
  assign rd_a        = r_rd_a;
  assign rd_b        = r_rd_b;
  assign rd_c        = r_rd_c;

endmodule
`default_nettype wire

// File: tb/tb_quadra_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_quadra_coef_loader
// Function : scoreboard bench with a frame-level reference model
// Revision : 1.0
// ============================================================================
module tb_quadra_coef_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        rd_en;
  logic [6:0]  rd_idx;
  logic        rd_vld;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        busy, table_valid, err, load_done;

  always #5 clk = ~clk;

  quadra_coef_loader #(.SEG_BITS(7), .COEF_W(32), .MAGIC(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_vld(rd_vld), .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .busy(busy), .table_valid(table_valid), .err(err), .load_done(load_done)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [95:0] exp_q[$];
  logic [95:0] last_rd = '0;
  bit          g_rd = 0;

  // Reference model: frame position arithmetic over a plain array.
  logic [95:0] m_tab [128];
  bit          m_in, m_dr, m_err, m_tv, m_ld;
  int          m_pos, m_k;
  int          m_base;
  logic [31:0] m_sa, m_sb;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_word(input logic [31:0] d, input bit l);
    int f, seg;
    if (!m_in && !m_dr) begin
      if (d[31:24] == 8'hA5) begin
        m_err = l;
        m_tv  = 0;
        if (!l) begin
          m_in = 1; m_base = int'(d[6:0]); m_k = int'(d[23:16]); m_pos = 0;
        end
      end else begin
        m_err = 1;
        if (!l) m_dr = 1;
      end
    end else if (m_dr) begin
      if (l) m_dr = 0;
    end else begin
      f   = m_pos % 3;
      seg = m_pos / 3;
      if (f == 0) m_sa = d;
      else if (f == 1) m_sb = d;
      else m_tab[(m_base + seg) % 128] = {m_sa, m_sb, d};
      m_pos++;
      if (l) begin
        m_in = 0;
        if (f == 2 && seg == m_k) begin m_tv = 1; m_ld = 1; end
        else m_err = 1;
      end else if (f == 2 && seg == m_k) begin
        m_in = 0; m_dr = 1; m_err = 1;
      end
    end
  endtask

  // One clock: drive, record expectations, advance, check status.
  task automatic cyc(input bit v, input logic [31:0] d, input bit l,
                     input bit re, input logic [6:0] ri);
    s_valid = v; s_data = d; s_last = l; rd_en = re; rd_idx = ri;
    if (re) exp_q.push_back(m_tab[ri]);
    m_ld = 0;
    if (v) model_word(d, l);
    @(posedge clk); #1;
    chk("s_ready",     96'(s_ready),     96'(1'b1));
    chk("busy",        96'(busy),        96'(m_in || m_dr));
    chk("err",         96'(err),         96'(m_err));
    chk("table_valid", 96'(table_valid), 96'(m_tv));
    chk("load_done",   96'(load_done),   96'(m_ld));
    s_valid = 0; s_last = 0; rd_en = 0;
  endtask

  task automatic rnd_rd(output bit re, output logic [6:0] ri);
    re = g_rd && ($urandom_range(0, 2) == 0);
    ri = 7'($urandom_range(0, 127));
  endtask

  task automatic send(input logic [31:0] d, input bit l, input bit gaps);
    bit re; logic [6:0] ri;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rnd_rd(re, ri);
        cyc(0, 32'h0, 0, re, ri);
      end
    end
    rnd_rd(re, ri);
    cyc(1, d, l, re, ri);
  endtask

  task automatic rd(input logic [6:0] ri);
    cyc(0, 32'h0, 0, 1, ri);
  endtask

  function automatic logic [31:0] hdr(input int k, input int base);
    return {8'hA5, 8'(k), 9'h0, 7'(base)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_unexpected: got rd_vld=1 expected no read at %0t", $time);
        end else begin
          chk("rd_data", {rd_a, rd_b, rd_c}, exp_q.pop_front());
        end
        last_rd = {rd_a, rd_b, rd_c};
      end else begin
        chk("rd_hold", {rd_a, rd_b, rd_c}, last_rd);
      end
    end
  end

  initial begin
    int          k, n, kind;
    logic [31:0] w;
    rst = 1; s_valid = 0; s_data = 0; s_last = 0; rd_en = 0; rd_idx = 0;
    m_in = 0; m_dr = 0; m_err = 0; m_tv = 0; m_ld = 0; m_pos = 0; m_k = 0; m_base = 0;
    #12;
    chk("s_ready_in_reset", 96'(s_ready), 96'(1'b0));
    chk("busy_reset", 96'(busy), 96'(1'b0));
    rst = 0;
    @(posedge clk); #1;
    chk("s_ready_after_rel", 96'(s_ready), 96'(1'b1));

    // Fill the whole table so every later read has a defined expectation.
    send(hdr(127, 0), 0, 0);
    for (int i = 0; i < 384; i++) send($urandom, i == 383, 0);
    g_rd = 1;

    send(32'hA500_0005, 0, 0);
    send(32'h4000_0000, 0, 0);
    send(32'hC000_0000, 0, 0);
    send(32'h0000_1000, 1, 0);
    rd(7'd5);

    send(32'hA501_007F, 0, 1);
    for (int i = 0; i < 6; i++) send($urandom, i == 5, 1);
    rd(7'd127); rd(7'd0); rd(7'd1);

    send(32'h1234_0000, 0, 1);
    send($urandom, 0, 1);
    send($urandom, 0, 1);
    send($urandom, 1, 1);
    send(hdr(0, 3), 0, 1);
    for (int i = 0; i < 3; i++) send($urandom, i == 2, 1);

    send(hdr(2, 10), 0, 1);
    for (int i = 0; i < 5; i++) send($urandom, i == 4, 1);
    rd(7'd10); rd(7'd11);

    send(hdr(0, 5), 0, 0);
    send($urandom, 0, 0);
    send($urandom, 0, 0);
    cyc(1, $urandom, 1, 1, 7'd5);
    rd(7'd5);

    // Asynchronous reset in the middle of a frame.
    send(hdr(3, 40), 0, 0);
    send($urandom, 0, 0);
    cyc(1, $urandom, 0, 1, 7'd40);
    #2 rst = 1;
    #1;
    chk("rst_busy",   96'(busy),        96'(1'b0));
    chk("rst_err",    96'(err),         96'(1'b0));
    chk("rst_tv",     96'(table_valid), 96'(1'b0));
    chk("rst_ld",     96'(load_done),   96'(1'b0));
    chk("rst_rd_vld", 96'(rd_vld),      96'(1'b0));
    chk("rst_rd",     {rd_a, rd_b, rd_c}, 96'h0);
    chk("rst_ready",  96'(s_ready),     96'(1'b0));
    exp_q.delete();
    last_rd = '0;
    m_in = 0; m_dr = 0; m_err = 0; m_tv = 0;
    @(posedge clk); #2 rst = 0;
    @(posedge clk); #1;
    chk("s_ready_after_rst", 96'(s_ready), 96'(1'b1));

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      k = ($urandom_range(0, 7) == 0) ? $urandom_range(130, 150) : $urandom_range(0, 3);
      case (kind)
        0: begin
          send(hdr(k, $urandom_range(0, 127)), 0, 1);
          for (int i = 0; i < 3 * (k + 1); i++) send($urandom, i == 3 * (k + 1) - 1, 1);
        end
        1: begin
          n = $urandom_range(0, 3 * (k + 1) - 1);
          send(hdr(k, $urandom_range(0, 127)), n == 0, 1);
          for (int i = 1; i <= n; i++) send($urandom, i == n, 1);
        end
        2: begin
          w = $urandom;
          if (w[31:24] == 8'hA5) w[31:24] = 8'h00;
          n = $urandom_range(0, 3);
          send(w, n == 0, 1);
          for (int i = 1; i <= n; i++) send($urandom, i == n, 1);
        end
        default: begin
          send(hdr(k, $urandom_range(0, 127)), 0, 1);
          for (int i = 0; i < 3 * (k + 1); i++) send($urandom, 0, 1);
          n = $urandom_range(1, 2);
          for (int i = 1; i <= n; i++) send($urandom, i == n, 1);
        end
      endcase
    end

    g_rd = 0;
    for (int i = 0; i < 128; i++) rd(7'(i));
    repeat (3) cyc(0, 32'h0, 0, 0, 7'd0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rd_missing: got %0d reads outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
